fifo_2: RTL

Parametrised synchronous single-clock FIFO. It generalises the 8-entry, 8-bit fifo_1 in both width and depth. It adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. It is used as a buffer between producer and consumer blocks in the same clock domain.

---
 rtl/fifo_2_if.sv | 28 ++
 rtl/fifo_2.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_2_if.sv
// Producer/consumer-side signal bundle for fifo_2.
// The master modport faces the FIFO user; the slave modport is the FIFO itself.
interface fifo_2_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 3
);
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write, read, write_data,
    input  read_data, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write, read, write_data,
    output read_data, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_2.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and error pulses.
// Define FIFO_2_FWFT_EN for first-word fall-through; otherwise read_data is registered.
module fifo_2 #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned PTR_WIDTH        = 3,
  parameter int unsigned ALMOST_FULL_LVL  = 6,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
  input  logic     clk,
  input  logic     rst,
  fifo_2_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_LVL    = (PTR_WIDTH + 1)'(ALMOST_FULL_LVL);
  localparam logic [PTR_WIDTH:0] AE_LVL    = (PTR_WIDTH + 1)'(ALMOST_EMPTY_LVL);
  localparam logic [PTR_WIDTH:0] PTR_ONE   = (PTR_WIDTH + 1)'(1);

  if (ALMOST_FULL_LVL > DEPTH) begin : g_af_lvl_check
    $error("fifo_2: ALMOST_FULL_LVL must be <= DEPTH");
  end
  if (ALMOST_EMPTY_LVL >= DEPTH) begin : g_ae_lvl_check
    $error("fifo_2: ALMOST_EMPTY_LVL must be < DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0] count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               almost_full_q, almost_full_d;
  logic               almost_empty_q, almost_empty_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               wr_acc, rd_acc;
  logic [PTR_WIDTH-1:0] wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];

  always_comb begin
    // A read in the same cycle frees a slot, so a write at full still lands.
    wr_acc   = bus.write & (~full_q | bus.read);
    rd_acc   = bus.read & ~empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    // Extra wrap bit makes the modular difference the true occupancy.
    count_d        = wr_ptr_d - rd_ptr_d;
    empty_d        = (count_d == '0);
    full_d         = (count_d == DEPTH_CNT);
    almost_full_d  = (count_d >= AF_LVL);
    almost_empty_d = (count_d <= AE_LVL);
    overflow_d     = bus.write & full_q & ~bus.read;
    underflow_d    = bus.read & empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_addr] <= bus.write_data;
    end
  end

`ifdef FIFO_2_FWFT_EN
  assign bus.read_data = mem[rd_addr];
`else
  logic [DATA_WIDTH-1:0] read_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q <= '0;
    end else if (rd_acc) begin
      read_data_q <= mem[rd_addr];
    end
  end

  assign bus.read_data = read_data_q;
`endif

  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
